// File: rtl/wb_pkg.sv
// Shared widths, default parameters and the write-back entry type for the
// write-back arbiter (wb_arbiter) and its LSU result FIFO (wb_fifo).
package wb_pkg;

    localparam int unsigned REG_AW                = 5;
    localparam int unsigned XLEN                  = 32;
    localparam int unsigned WB_DEPTH_DEFAULT      = 2;
    localparam int unsigned WB_STARVE_MAX_DEFAULT = 4;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// LSU result FIFO: power-of-two depth, wrapping pointers, occupancy count.
// Callers must not push while full or pop while empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head_c,
    output logic      full_c,
    output logic      empty_c
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_entry_t         mem_q [DEPTH];
    wb_entry_t         mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards any queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results with queued LSU results
// onto one register-file write port. ALU has priority; a starvation counter
// raises stall_req so queued LSU results eventually drain.
// Optional macro WB_BYPASS_EN: an LSU result arriving with the FIFO empty and
// no ALU result is written directly (1-cycle latency) instead of queued.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH      = WB_DEPTH_DEFAULT,
    parameter int unsigned STARVE_MAX = WB_STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              reg_write,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   rd_data,
    output logic              stall_req
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    wb_entry_t         fifo_head_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic              lsu_accept;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              win_valid;
    wb_entry_t         win;

    logic              reg_write_q, reg_write_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic              stall_req_q, stall_req_d;
    logic [SW-1:0]     starve_q, starve_d;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign lsu_ready = rst_n && !fifo_full_c;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (wb_entry_t'({lsu_rd, lsu_data})),
        .pop       (pop),
        .head_c    (fifo_head_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

    // Winner selection: ALU, else FIFO head, else (optionally) bypassed LSU.
    always_comb begin
        lsu_accept = lsu_valid && lsu_ready;
        bypass     = 1'b0;
`ifdef WB_BYPASS_EN
        bypass     = lsu_accept && fifo_empty_c && !alu_valid;
`endif
        push       = lsu_accept && !bypass;
        pop        = 1'b0;
        win_valid  = 1'b0;
        win        = '0;
        if (alu_valid) begin
            win_valid = 1'b1;
            win       = '{rd: alu_rd, data: alu_data};
        end else if (!fifo_empty_c) begin
            pop       = 1'b1;
            win_valid = 1'b1;
            win       = fifo_head_c;
        end else if (bypass) begin
            win_valid = 1'b1;
            win       = '{rd: lsu_rd, data: lsu_data};
        end
    end

    // Output and starvation next-state; x0 winners are consumed silently.
    always_comb begin
        reg_write_d = win_valid && (win.rd != '0);
        rd_d        = rd_q;
        rd_data_d   = rd_data_q;
        if (win_valid) begin
            rd_d      = win.rd;
            rd_data_d = win.data;
        end
        starve_d = starve_q;
        if (pop || fifo_empty_c) begin
            starve_d = '0;
        end else if (alu_valid && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
        stall_req_d = (starve_d == SW'(STARVE_MAX));
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            rd_data_q   <= '0;
            stall_req_q <= 1'b0;
            starve_q    <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            rd_data_q   <= rd_data_d;
            stall_req_q <= stall_req_d;
            starve_q    <= starve_d;
        end
    end

    assign reg_write = reg_write_q;
    assign rd        = rd_q;
    assign rd_data   = rd_data_q;
    assign stall_req = stall_req_q;

endmodule
